// File: rtl/alu_seq_if.sv
// Operand-issue and result-return handshake bundle for alu_seq.
// The slave modport is the ALU side; master is the issuer/consumer side.
interface alu_seq_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             c;
    logic             zero;
    logic             overflow;
    logic             smaller;
    logic             equal;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, c, zero, overflow, smaller, equal
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, c, zero, overflow, smaller, equal
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides: single-cycle add/sub/logic/compare
// and a WIDTH-cycle unsigned shift-add multiply; results are held until accepted.
module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam int MSB   = WIDTH - 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_NOT = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SLT = 4'd6;
    localparam logic [3:0] OP_EQ  = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]   r_result;
    logic               r_c;
    logic               r_zero;
    logic               r_ovf;
    logic               r_lt;
    logic               r_eq;

    logic               w_accept;
    logic               w_is_mul;
    logic               w_last;
    logic [WIDTH-1:0]   w_acc_nxt;

    logic               w_sub;
    logic               w_arith;
    logic [WIDTH-1:0]   w_bb;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic               w_ovf;
    logic               w_lt;
    logic               w_eq;
    logic [WIDTH-1:0]   w_res;

    assign w_accept  = bus.in_valid & (r_state == S_IDLE);
    assign w_is_mul  = (bus.op == OP_MUL);
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.result    = r_result;
    assign bus.c         = r_c;
    assign bus.zero      = r_zero;
    assign bus.overflow  = r_ovf;
    assign bus.smaller   = r_lt;
    assign bus.equal     = r_eq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid) w_state_nxt = w_is_mul ? S_BUSY : S_DONE;
            S_BUSY:  if (w_last)       w_state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // SUB/SLT/EQ share one adder as a + ~b + 1; compare flags fall out of it.
    always_comb begin
        w_sub   = (bus.op == OP_SUB) | (bus.op == OP_SLT) | (bus.op == OP_EQ);
        w_arith = w_sub | (bus.op == OP_ADD);
        w_bb    = w_sub ? ~bus.b : bus.b;
        {w_cout, w_sum} = {1'b0, bus.a} + {1'b0, w_bb} + {{WIDTH{1'b0}}, w_sub};
        if (w_sub) begin
            w_ovf = (bus.a[MSB] != bus.b[MSB]) & (w_sum[MSB] != bus.a[MSB]);
        end else begin
            w_ovf = (bus.a[MSB] == bus.b[MSB]) & (w_sum[MSB] != bus.a[MSB]);
        end
        w_lt = w_sum[MSB] ^ w_ovf;
        w_eq = (w_sum == '0);
        w_res = '0;
        case (bus.op)
            OP_ADD, OP_SUB: w_res = w_sum;
            OP_NOT:         w_res = ~bus.a;
            OP_AND:         w_res = bus.a & bus.b;
            OP_OR:          w_res = bus.a | bus.b;
            OP_XOR:         w_res = bus.a ^ bus.b;
            OP_SLT:         w_res = {{(WIDTH-1){1'b0}}, w_lt};
            OP_EQ:          w_res = {{(WIDTH-1){1'b0}}, w_eq};
            default:        w_res = '0;
        endcase
    end

    // Multiply consumes one multiplier bit per BUSY cycle, LSB first; the
    // last step writes the result directly so DONE follows WIDTH BUSY cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_c      <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_lt     <= 1'b0;
            r_eq     <= 1'b0;
        end else if (w_accept) begin
            if (w_is_mul) begin
                r_mcand  <= bus.a;
                r_mplier <= bus.b;
                r_acc    <= '0;
                r_cnt    <= '0;
            end else begin
                r_result <= w_res;
                r_c      <= w_arith & w_cout;
                r_ovf    <= w_arith & w_ovf;
                r_lt     <= w_sub & w_lt;
                r_eq     <= w_sub & w_eq;
                r_zero   <= (w_res == '0);
            end
        end else if (r_state == S_BUSY) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_result <= w_acc_nxt;
                r_c      <= 1'b0;
                r_ovf    <= 1'b0;
                r_lt     <= 1'b0;
                r_eq     <= 1'b0;
                r_zero   <= (w_acc_nxt == '0);
            end
        end
    end
endmodule
